// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM: one shared period counter, CHANNELS comparators, shadow/active duty per channel.
// Latency: pwm_out is registered one clock behind the counter; shadow duty reaches the comparator at the next period boundary.
// Backpressure: none; en=0 freezes counter, active duty and outputs while shadow duties keep accepting updates.
// Optional feature macro: PWM_CENTER_ALIGN_EN selects an up/down triangle counter instead of the sawtooth.
module pwm_multi_ctrl #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STEP     = 1,
    parameter int DUTY_RST = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         load,
    input  logic [CHANNELS*WIDTH-1:0]    duty_in,
    input  logic [CHANNELS-1:0]          duty_inc,
    input  logic [CHANNELS-1:0]          duty_dec,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_start,
    output logic [CHANNELS*WIDTH-1:0]    duty_active
);

    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH:0]   STEP_W     = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] DUTY_RST_W = WIDTH'(DUTY_RST);

    // Per-channel duty storage; channel c occupies bits [c*WIDTH +: WIDTH].
    logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0][WIDTH-1:0] active_q, active_d;

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] inc_q, dec_q;
    logic [CHANNELS-1:0] inc_evt, dec_evt;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                period_start_q, period_start_d;
    logic                wrap;

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_down_q, dir_down_d;

    // Triangle counter 0..MAX..1,0: the ends are visited once each, so the period is 2*MAX clocks.
    always_comb begin
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        wrap       = 1'b0;
        if (en) begin
            if (!dir_down_q) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d      = cnt_q - 1'b1;
                    dir_down_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q <= WIDTH'(1)) begin
                    // Bottom of the triangle: this edge is the period boundary.
                    cnt_d      = '0;
                    dir_down_d = 1'b0;
                    wrap       = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end
`else
    // Sawtooth counter; the MAX -> 0 edge is the period boundary.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (en) begin
            cnt_d = cnt_q + 1'b1;
            wrap  = (cnt_q == CNT_MAX);
        end
    end
`endif

    // Rising-edge detect on the step requests and saturating shadow update (load has priority).
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] diff;
        sum      = '0;
        diff     = '0;
        inc_evt  = duty_inc & ~inc_q;
        dec_evt  = duty_dec & ~dec_q;
        shadow_d = shadow_q;
        if (load) begin
            shadow_d = duty_in;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum  = {1'b0, shadow_q[c]} + STEP_W;
                diff = {1'b0, shadow_q[c]} - STEP_W;
                if (inc_evt[c] && !dec_evt[c]) begin
                    shadow_d[c] = (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[WIDTH-1:0];
                end else if (dec_evt[c] && !inc_evt[c]) begin
                    // A borrow out of the extra bit means the result went below zero.
                    shadow_d[c] = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
                end
            end
        end
    end

    // Boundary transfer and comparators; the compare uses the pre-transfer active value on the boundary edge.
    // In triangle mode active > cnt yields 2*D-1 high clocks because the bottom value 0 occurs once per period.
    always_comb begin
        active_d       = wrap ? shadow_q : active_q;
        period_start_d = wrap;
        pwm_d          = pwm_q;
        if (en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pwm_d[c] = (active_q[c] > cnt_q);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            shadow_q       <= {CHANNELS{DUTY_RST_W}};
            active_q       <= {CHANNELS{DUTY_RST_W}};
            inc_q          <= '0;
            dec_q          <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_q     <= 1'b0;
`endif
        end else begin
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            inc_q          <= duty_inc;
            dec_q          <= duty_dec;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_q     <= dir_down_d;
`endif
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign duty_active  = active_q;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Bench for pwm_multi_ctrl: directed stimulus pushes expected per-period results into a scoreboard,
// a monitor pops them on each period_start pulse and checks active duty, period length and high-time.
// A second instance with STEP=16 and one channel covers the large-step saturation case.
module tb_pwm_multi_ctrl;

    localparam int W  = 8;
    localparam int CH = 4;
`ifdef PWM_CENTER_ALIGN_EN
    localparam int PER    = 510;
    localparam bit CENTER = 1'b1;
`else
    localparam int PER    = 256;
    localparam bit CENTER = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              load;
    logic [CH*W-1:0]   duty_in;
    logic [CH-1:0]     duty_inc;
    logic [CH-1:0]     duty_dec;
    logic [CH-1:0]     pwm_out;
    logic              period_start;
    logic [CH*W-1:0]   duty_active;

    logic              s_load;
    logic [W-1:0]      s_duty_in;
    logic [0:0]        s_inc;
    logic [0:0]        s_dec;
    logic [0:0]        s_pwm_out;
    logic              s_period_start;
    logic [W-1:0]      s_duty_active;

    pwm_multi_ctrl #(.WIDTH(W), .CHANNELS(CH), .STEP(1), .DUTY_RST(0)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .load         (load),
        .duty_in      (duty_in),
        .duty_inc     (duty_inc),
        .duty_dec     (duty_dec),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_active  (duty_active)
    );

    pwm_multi_ctrl #(.WIDTH(W), .CHANNELS(1), .STEP(16), .DUTY_RST(0)) u_s16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .load         (s_load),
        .duty_in      (s_duty_in),
        .duty_inc     (s_inc),
        .duty_dec     (s_dec),
        .pwm_out      (s_pwm_out),
        .period_start (s_period_start),
        .duty_active  (s_duty_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int                   pidx;
        logic [CH*W-1:0]      duty;
        bit                   chk_hi;
        logic [CH-1:0][15:0]  hi;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   sp     = 0;
    bit   mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected high clocks per period for a steady duty d.
    function automatic logic [15:0] hi_of(input int d);
        if (CENTER) return (d == 0) ? 16'd0 : 16'(2*d - 1);
        return 16'(d);
    endfunction

    task automatic push(input int p, input logic [CH*W-1:0] d, input bit ch);
        exp_t e;
        logic [W-1:0] sl;
        e.pidx   = p;
        e.duty   = d;
        e.chk_hi = ch;
        for (int c = 0; c < CH; c++) begin
            sl      = d[c*W +: W];
            e.hi[c] = hi_of(int'(sl));
        end
        sb.push_back(e);
    endtask

    // Monitor: one window per period, delimited by period_start.
    int                  pidx    = 0;
    int                  win_len = 0;
    int                  hi_cnt[CH];
    bit                  cur_chk_hi = 1'b0;
    logic [CH-1:0][15:0] cur_hi;

    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_on && rst_n) begin
            if (period_start) begin
                pidx++;
                if (pidx > 1) check($sformatf("period_len_p%0d", pidx), win_len, PER);
                if (cur_chk_hi) begin
                    for (int c = 0; c < CH; c++)
                        check($sformatf("high_clks_ch%0d_p%0d", c, pidx - 1), hi_cnt[c], 32'(cur_hi[c]));
                end
                cur_chk_hi = 1'b0;
                win_len    = 0;
                for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
                while (sb.size() > 0 && sb[0].pidx < pidx) begin
                    e = sb.pop_front();
                    check("scoreboard_period_missed", e.pidx, pidx);
                end
                if (sb.size() > 0 && sb[0].pidx == pidx) begin
                    e = sb.pop_front();
                    check($sformatf("duty_active_p%0d", pidx), duty_active, e.duty);
                    cur_chk_hi = e.chk_hi;
                    cur_hi     = e.hi;
                end
            end
            win_len++;
            for (int c = 0; c < CH; c++) if (pwm_out[c]) hi_cnt[c]++;
        end
    end

    // Advance to the next period_start pulse, bounded.
    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!period_start && n < 2*PER + 4);
        check($sformatf("period_start_seen_%0d", sp + 1), period_start, 1);
        sp++;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; duty_in = '0; duty_inc = '0; duty_dec = '0;
        s_load = 1'b0; s_duty_in = '0; s_inc = '0; s_dec = '0;

        // Reset values.
        repeat (3) @(posedge clk); #1;
        check("rst_pwm_out", pwm_out, 0);
        check("rst_duty_active", duty_active, 0);
        check("rst_period_start", period_start, 0);
        rst_n = 1'b1; en = 1'b1; mon_on = 1'b1;

        // Mid-period load: held off until the boundary.
        wait_ps();
        repeat (50) @(posedge clk); #1;
        duty_in = {8'd255, 8'd200, 8'd0, 8'd64};
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("active_unchanged_before_wrap", duty_active, 0);
        push(2, {8'd255, 8'd200, 8'd0, 8'd64}, 1'b0);
        push(3, {8'd255, 8'd200, 8'd0, 8'd64}, 1'b1);
        wait_ps();
        wait_ps();

        // Held inc/dec give one step; 255+1 saturates; STEP=16: 250+16 saturates to 255.
        repeat (20) @(posedge clk); #1;
        duty_inc = 4'b1010; duty_dec = 4'b0100;
        s_duty_in = 8'd250; s_load = 1'b1;
        @(posedge clk); #1; s_load = 1'b0; s_inc = 1'b1;
        @(posedge clk); #1; s_inc = 1'b0;
        @(posedge clk); #1; s_inc = 1'b1;
        @(posedge clk); #1; s_inc = 1'b0;
        repeat (6) @(posedge clk); #1;
        duty_inc = '0; duty_dec = '0;
        check("active_hold_mid_period", duty_active, {8'd255, 8'd200, 8'd0, 8'd64});
        push(4, {8'd255, 8'd199, 8'd1, 8'd64}, 1'b0);
        wait_ps();
        check("s16_period_start", s_period_start, 1);
        check("s16_sat_inc_250", s_duty_active, 255);

        // Load beats a same-cycle inc; 0-1 saturates at 0; simultaneous inc+dec is a no-op.
        repeat (20) @(posedge clk); #1;
        duty_in = {8'd5, 8'd100, 8'd10, 8'd0};
        load = 1'b1; duty_inc = 4'b0010; s_dec = 1'b1;
        @(posedge clk); #1; load = 1'b0; s_dec = 1'b0;
        @(posedge clk); #1; duty_inc = '0;
        @(posedge clk); #1; duty_dec = 4'b0101; duty_inc = 4'b0100;
        @(posedge clk); #1; duty_dec = '0; duty_inc = '0;
        push(5, {8'd5, 8'd100, 8'd10, 8'd0}, 1'b0);
        push(6, {8'd5, 8'd100, 8'd10, 8'd0}, 1'b1);
        wait_ps();
        check("s16_dec_255", s_duty_active, 239);
        wait_ps();

        // Load sampled on the boundary edge itself waits a full period.
        repeat (PER - 1) @(posedge clk); #1;
        duty_in = {8'd3, 8'd2, 8'd1, 8'd128};
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check("period_start_on_load_edge", period_start, 1);
        sp++;
        push(7, {8'd5, 8'd100, 8'd10, 8'd0}, 1'b1);
        push(8, {8'd3, 8'd2, 8'd1, 8'd128}, 1'b0);
        push(9, {8'd3, 8'd2, 8'd1, 8'd128}, 1'b1);
        wait_ps();
        wait_ps();
        wait_ps();

        // Asynchronous reset mid-period, sampled between clock edges.
        repeat (30) @(posedge clk); #1;
        check("pwm0_high_before_rst", pwm_out[0], 1);
        check("s16_pwm_high_before_rst", s_pwm_out, 1);
        check("scoreboard_drained", sb.size(), 0);
        mon_on = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm_out", pwm_out, 0);
        check("async_rst_duty_active", duty_active, 0);
        check("async_rst_period_start", period_start, 0);
        check("async_rst_s16_duty", s_duty_active, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
